// File: rtl/fpu_conv_wb_queue.sv
// Writeback result queue behind the int/float converters: two producers are
// arbitrated round-robin into a first-word-fall-through FIFO that feeds the FP regfile write port.
module fpu_conv_wb_queue #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in0_valid,
    input  logic [TAGW-1:0]          in0_tag,
    input  logic [31:0]              in0_data,
    output logic                     in0_ready,
    input  logic                     in1_valid,
    input  logic [TAGW-1:0]          in1_tag,
    input  logic [31:0]              in1_data,
    output logic                     in1_ready,
    output logic                     out_valid,
    output logic [TAGW-1:0]          out_tag,
    output logic [31:0]              out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [TAGW-1:0] tag_q  [DEPTH];
    logic [31:0]     data_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          rr_q, rr_d;

    logic            full, empty;
    logic            acc0, acc1;
    logic            enq_store, deq;
    logic [TAGW-1:0] enq_tag;
    logic [31:0]     enq_data;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Ready ignores out_ready on purpose: no pass-through into a full queue.
    assign in0_ready = !full && !flush && (!in1_valid || !rr_q);
    assign in1_ready = !full && !flush && (!in0_valid ||  rr_q);

    assign acc0 = in0_valid && in0_ready;
    assign acc1 = in1_valid && in1_ready;

    always_comb begin
        enq_tag   = in1_tag;
        enq_data  = in1_data;
        enq_store = 1'b0;
        if (acc0) begin
            enq_tag   = in0_tag;
            enq_data  = in0_data;
            enq_store = (in0_tag != '0);
        end else if (acc1) begin
            enq_store = (in1_tag != '0);
        end
    end

    assign deq = !empty && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rr_d     = rr_q;
        if (rst || flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            rr_d     = 1'b0;
        end else begin
            if (enq_store) wr_ptr_d = wr_ptr_q + 1'b1;
            if (deq)       rd_ptr_d = rd_ptr_q + 1'b1;
            case ({enq_store, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            // Tag-0 results still take their arbitration turn.
            if (acc0)      rr_d = 1'b1;
            else if (acc1) rr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        rr_q     <= rr_d;
    end

    // Storage payload carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (enq_store && !rst) begin
            tag_q[wr_ptr_q]  <= enq_tag;
            data_q[wr_ptr_q] <= enq_data;
        end
    end

    assign out_valid = !empty;
    assign out_tag   = empty ? '0 : tag_q[rd_ptr_q];
    assign out_data  = empty ? '0 : data_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: tb/tb_fpu_conv_wb_queue.sv
// Self-checking bench for fpu_conv_wb_queue: directed scenarios plus a
// randomized run, all compared against a queue-based behavioural model.
module tb_fpu_conv_wb_queue;

    localparam int DEPTH = 4;
    localparam int TAGW  = 6;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 0;
    logic            rst = 0, flush = 0;
    logic            in0_valid = 0, in1_valid = 0, out_ready = 0;
    logic [TAGW-1:0] in0_tag = '0, in1_tag = '0;
    logic [31:0]     in0_data = '0, in1_data = '0;
    logic            in0_ready, in1_ready, out_valid;
    logic [TAGW-1:0] out_tag;
    logic [31:0]     out_data;
    logic [CW-1:0]   count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [31:0]     data;
    } ent_t;

    ent_t mq[$];
    bit   m_rr = 0;

    fpu_conv_wb_queue #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in0_valid(in0_valid), .in0_tag(in0_tag), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_tag(in1_tag), .in1_data(in1_data), .in1_ready(in1_ready),
        .out_valid(out_valid), .out_tag(out_tag), .out_data(out_data), .out_ready(out_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic e_rdy0();
        return (mq.size() < DEPTH) && !flush && (!in1_valid || m_rr == 0);
    endfunction

    function automatic logic e_rdy1();
        return (mq.size() < DEPTH) && !flush && (!in0_valid || m_rr == 1);
    endfunction

    function automatic logic [TAGW-1:0] e_tag();
        return (mq.size() != 0) ? mq[0].tag : '0;
    endfunction

    function automatic logic [31:0] e_data();
        return (mq.size() != 0) ? mq[0].data : 32'h0;
    endfunction

    // Called at a negedge with inputs settled; advances the model across the next posedge.
    task automatic model_step();
        logic a0, a1, dq, clr;
        ent_t e0, e1;
        a0  = in0_valid && e_rdy0();
        a1  = in1_valid && e_rdy1();
        dq  = (mq.size() != 0) && out_ready;
        clr = rst || flush;
        e0  = '{tag: in0_tag, data: in0_data};
        e1  = '{tag: in1_tag, data: in1_data};
        @(posedge clk);
        if (clr) begin
            mq.delete();
            m_rr = 0;
        end else begin
            if (dq) mq.delete(0);
            if (a0) begin
                if (e0.tag != 0) mq.push_back(e0);
                m_rr = 1;
            end else if (a1) begin
                if (e1.tag != 0) mq.push_back(e1);
                m_rr = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        in0_valid = 0; in1_valid = 0; out_ready = 0; flush = 0;
        rst = 1;
        @(negedge clk);
        model_step();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag: got %0h expected 0", out_tag); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (in0_ready !== 1'b1) begin errors++; $display("FAIL reset_in0_ready: got %0b expected 1", in0_ready); end
        checks++; if (in1_ready !== 1'b1) begin errors++; $display("FAIL reset_in1_ready: got %0b expected 1", in1_ready); end
    endtask

    task automatic test_first_word();
        do_reset();
        in0_valid = 1; in0_tag = 5; in0_data = 32'h3F80_0000;
        @(negedge clk);
        checks++; if (in0_ready !== 1'b1) begin errors++; $display("FAIL first_in0_ready: got %0b expected 1", in0_ready); end
        model_step();
        in0_valid = 0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_out_valid: got %0b expected 1", out_valid); end
        checks++; if (out_tag !== 5) begin errors++; $display("FAIL first_out_tag: got %0d expected 5", out_tag); end
        checks++; if (out_data !== 32'h3F80_0000) begin errors++; $display("FAIL first_out_data: got %0h expected 3f800000", out_data); end
        checks++; if (count !== 1) begin errors++; $display("FAIL first_count: got %0d expected 1", count); end
        out_ready = 1;
        model_step();
        out_ready = 0;
    endtask

    task automatic test_alternate();
        int i0 = 0, i1 = 0;
        logic [TAGW-1:0] got[$];
        logic [TAGW-1:0] exp_t;
        logic a0, a1;
        do_reset();
        out_ready = 1;
        for (int c = 0; c < 60 && got.size() < 16; c++) begin
            in0_valid = (i0 < 8); in0_tag = TAGW'(i0 + 1); in0_data = 32'hA000_0000 | (i0 + 1);
            in1_valid = (i1 < 8); in1_tag = TAGW'(i1 + 9); in1_data = 32'hB000_0000 | (i1 + 9);
            @(negedge clk);
            checks++; if (in0_ready !== e_rdy0()) begin errors++; $display("FAIL alt_in0_ready: got %0b expected %0b", in0_ready, e_rdy0()); end
            checks++; if (in1_ready !== e_rdy1()) begin errors++; $display("FAIL alt_in1_ready: got %0b expected %0b", in1_ready, e_rdy1()); end
            checks++; if (out_data !== e_data()) begin errors++; $display("FAIL alt_out_data: got %0h expected %0h", out_data, e_data()); end
            if (out_valid) got.push_back(out_tag);
            a0 = in0_valid && in0_ready;
            a1 = in1_valid && in1_ready;
            model_step();
            if (a0) i0++;
            if (a1) i1++;
        end
        in0_valid = 0; in1_valid = 0;
        checks++; if (got.size() != 16) begin errors++; $display("FAIL alt_out_count: got %0d expected 16", got.size()); end
        for (int k = 0; k < 16 && k < got.size(); k++) begin
            exp_t = TAGW'((k % 2 == 0) ? (k / 2 + 1) : (k / 2 + 9));
            checks++; if (got[k] !== exp_t) begin errors++; $display("FAIL alt_order[%0d]: got %0d expected %0d", k, got[k], exp_t); end
        end
        out_ready = 0;
    endtask

    task automatic test_full();
        logic [TAGW-1:0] got[$];
        logic a0;
        do_reset();
        out_ready = 0;
        for (int t = 1; t <= DEPTH + 1; t++) begin
            in0_valid = 1; in0_tag = TAGW'(t); in0_data = 32'h4000_0000 + t;
            @(negedge clk);
            checks++; if (in0_ready !== (t <= DEPTH)) begin errors++; $display("FAIL full_fill_ready[%0d]: got %0b expected %0b", t, in0_ready, (t <= DEPTH)); end
            if (t <= DEPTH) model_step();
        end
        checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL full_count: got %0d expected %0d", count, DEPTH); end
        out_ready = 1;
        #1;
        checks++; if (in0_ready !== 1'b0) begin errors++; $display("FAIL full_no_passthru: got %0b expected 0", in0_ready); end
        got.push_back(out_tag);
        model_step();
        @(negedge clk);
        checks++; if (count !== CW'(DEPTH - 1)) begin errors++; $display("FAIL full_count_after_deq: got %0d expected %0d", count, DEPTH - 1); end
        checks++; if (in0_ready !== 1'b1) begin errors++; $display("FAIL full_ready_return: got %0b expected 1", in0_ready); end
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (out_valid) got.push_back(out_tag);
            a0 = in0_valid && in0_ready;
            model_step();
            if (a0) in0_valid = 0;
            if (got.size() == DEPTH + 1) break;
        end
        checks++; if (got.size() != DEPTH + 1) begin errors++; $display("FAIL full_drain_count: got %0d expected %0d", got.size(), DEPTH + 1); end
        for (int k = 0; k < got.size(); k++) begin
            checks++; if (got[k] !== TAGW'(k + 1)) begin errors++; $display("FAIL full_order[%0d]: got %0d expected %0d", k, got[k], k + 1); end
        end
        in0_valid = 0; out_ready = 0;
    endtask

    task automatic test_tag_zero();
        do_reset();
        in0_valid = 1; in0_tag = 0; in0_data = 32'h1234_5678;
        @(negedge clk);
        model_step();
        in0_valid = 0;
        in1_valid = 1; in1_tag = 0; in1_data = 32'hC000_0000;
        @(negedge clk);
        checks++; if (in1_ready !== 1'b1) begin errors++; $display("FAIL tag0_in1_ready: got %0b expected 1", in1_ready); end
        model_step();
        in1_valid = 0;
        @(negedge clk);
        checks++; if (count !== '0) begin errors++; $display("FAIL tag0_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tag0_out_valid: got %0b expected 0", out_valid); end
        in0_valid = 1; in0_tag = 1; in0_data = 32'h1;
        in1_valid = 1; in1_tag = 2; in1_data = 32'h2;
        #1;
        checks++; if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin errors++; $display("FAIL tag0_rr: got %0b%0b expected 10", in0_ready, in1_ready); end
        model_step();
        in0_valid = 0; in1_valid = 0;
    endtask

    task automatic test_flush_rst(input bit use_rst);
        do_reset();
        out_ready = 0;
        for (int t = 3; t <= 5; t++) begin
            in0_valid = 1; in0_tag = TAGW'(t); in0_data = 32'h5000_0000 + t;
            @(negedge clk);
            model_step();
        end
        in0_tag = 7; in0_data = 32'h7;
        out_ready = 1;
        if (use_rst) rst = 1; else flush = 1;
        @(negedge clk);
        if (!use_rst) begin
            checks++; if (in0_ready !== 1'b0) begin errors++; $display("FAIL flush_in0_ready: got %0b expected 0", in0_ready); end
        end
        model_step();
        rst = 0; flush = 0; in0_valid = 0; out_ready = 0;
        @(negedge clk);
        checks++; if (count !== '0) begin errors++; $display("FAIL clear%0d_count: got %0d expected 0", use_rst, count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear%0d_out_valid: got %0b expected 0", use_rst, out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL clear%0d_out_data: got %0h expected 0", use_rst, out_data); end
    endtask

    task automatic test_random();
        logic a0, a1;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (!in0_valid && ($urandom % 3 != 0)) begin
                in0_valid = 1;
                in0_tag   = ($urandom % 8 == 0) ? '0 : TAGW'($urandom);
                in0_data  = $urandom;
            end
            if (!in1_valid && ($urandom % 3 != 0)) begin
                in1_valid = 1;
                in1_tag   = ($urandom % 8 == 0) ? '0 : TAGW'($urandom);
                in1_data  = $urandom;
            end
            out_ready = ((c / 50) % 2 == 1) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
            flush     = ($urandom % 60 == 0);
            @(negedge clk);
            checks++; if (in0_ready !== e_rdy0()) begin errors++; $display("FAIL rnd_in0_ready c%0d: got %0b expected %0b", c, in0_ready, e_rdy0()); end
            checks++; if (in1_ready !== e_rdy1()) begin errors++; $display("FAIL rnd_in1_ready c%0d: got %0b expected %0b", c, in1_ready, e_rdy1()); end
            checks++; if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_out_valid c%0d: got %0b expected %0b", c, out_valid, (mq.size() != 0)); end
            checks++; if (out_tag !== e_tag()) begin errors++; $display("FAIL rnd_out_tag c%0d: got %0h expected %0h", c, out_tag, e_tag()); end
            checks++; if (out_data !== e_data()) begin errors++; $display("FAIL rnd_out_data c%0d: got %0h expected %0h", c, out_data, e_data()); end
            checks++; if (count !== CW'(mq.size())) begin errors++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, count, mq.size()); end
            a0 = in0_valid && in0_ready;
            a1 = in1_valid && in1_ready;
            model_step();
            if (a0) in0_valid = 0;
            if (a1) in1_valid = 0;
        end
        in0_valid = 0; in1_valid = 0; flush = 0; out_ready = 0;
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_alternate();
        test_full();
        test_tag_zero();
        test_flush_rst(1'b0);
        test_flush_rst(1'b1);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_conv_wb_queue.md
# fpu_conv_wb_queue

Result queue directly downstream of the combinational int-to-float converter (and its sibling float-to-int converter) in the FPU. Accepts converted 32-bit results with destination-register tags from two producers, arbitrates them round-robin into a DEPTH-entry FIFO, and presents them one at a time to the FP register-file write port. It decouples the single-cycle converters from writeback stalls.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, 2..16
- TAGW, 6, destination-register tag width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  synchronous queue clear (pipeline flush)
- in0_valid  input  1  converter 0 (itof) result valid
- in0_tag  input  TAGW  converter 0 destination tag
- in0_data  input  32  converter 0 IEEE-754 single result
- in0_ready  output  1  converter 0 result accepted this cycle when high with in0_valid
- in1_valid / in1_tag / in1_data / in1_ready  same widths and meaning for converter 1
- out_valid  output  1  head entry valid
- out_tag  output  TAGW  head entry tag
- out_data  output  32  head entry data
- out_ready  input  1  writeback consumes head this cycle
- count  output  $clog2(DEPTH)+1  current occupancy

## Operation
- State: storage[DEPTH] of {tag, data}; wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH); count; rr (1 bit).
- full = (count == DEPTH); empty = (count == 0).
- Ready (combinational): in0_ready = !full & !flush & (!in1_valid | rr==0); in1_ready = !full & !flush & (!in0_valid | rr==1). At most one input enqueues per cycle.
- Enqueue: the input with valid & ready writes storage[wr_ptr], wr_ptr+1.
- Tag 0 (hard-wired zero register): accepted (ready obeys the rules above) but not stored; pointers and count unchanged; rr still updates.
- rr: after any accepted input, rr points to the other input (accept in0 -> rr=1, accept in1 -> rr=0). Unchanged if nothing is accepted.
- Dequeue: out_valid & out_ready -> rd_ptr+1.
- count next = count + enq_stored - deq. Simultaneous enqueue and dequeue keeps count constant.
- Output: out_valid = !empty. out_tag/out_data = storage[rd_ptr] when out_valid, else all zeros.
- Full: ready depends on full only, not on out_ready. There is no same-cycle pass-through into a full queue, even if a dequeue happens that cycle.
- Flush: the next edge sets count, wr_ptr, rd_ptr and rr to 0. Inputs are not accepted in the flush cycle, and a dequeue that cycle is discarded. flush has no other effect.
- rst: the same clearing as flush. Priority: rst > flush > normal operation.

## Timing
- Reset values: out_valid=0, out_tag=0, out_data=0, count=0, rr=0. in0_ready=in1_ready=1 after reset when the other input is idle.
- Latency: an input accepted at edge N appears on out_valid/out_tag/out_data from edge N (visible in cycle N+1). Minimum latency is 1 cycle, and the queue is first-word-fall-through.
- Throughput: 1 enqueue plus 1 dequeue per cycle sustained.
- Order: FIFO order of acceptance is preserved across both inputs.
- Producers must hold valid/tag/data stable until accepted. The queue never drops a non-zero-tag accepted entry except on flush/rst.
- out_* are stable while out_valid & !out_ready.

## Test plan
- After rst, in0 sends {tag=5, 0x3F800000} -> in0_ready=1; next cycle out_valid=1, out_tag=5, out_data=0x3F800000, count=1.
- Both inputs valid every cycle, tags 1..8 on in0 and 9..16 on in1, out_ready=1 -> accepts alternate in0,in1,in0,… starting with in0; output order is 1,9,2,10,…
- out_ready=0, feed in0 tags 1..DEPTH+1 -> count reaches DEPTH, in0_ready=0 on the 5th; enable out_ready -> in0_ready returns the cycle after the first dequeue; order preserved.
- Full queue, out_ready=1, in0_valid=1 same cycle -> no enqueue that cycle; count goes DEPTH -> DEPTH-1.
- in1 sends tag=0, data=0xC0000000 -> in1_ready=1, count stays 0, out_valid stays 0, rr flips to 0.
- 3 entries queued, assert flush with in0_valid=1 -> in0_ready=0 that cycle; next cycle count=0, out_valid=0, out_data=0. Repeat with rst mid-stream -> same result.
